comparatore_window_stream: RTL and testbench

//   Parametrised, registered window comparator with a valid/ready stream

---
 rtl/comparatore_window_stream_if.sv | 37 +++
 rtl/comparatore_window_stream.sv | 107 ++++++++++
 tb/tb_comparatore_window_stream.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparatore_window_stream_if.sv
// ============================================================================
//  Module      : comparatore_window_stream_if
//  Description : Sample/result stream bundle for the window comparator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface comparatore_window_stream_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic             in_window;
    logic             inv_win;
    logic             stable;
    logic [CNT_W-1:0] run_cnt;

    // Source/consumer side
    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, in_window, inv_win, stable, run_cnt
    );

    // Comparator side
    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, in_window, inv_win, stable, run_cnt
    );
endinterface

`default_nettype wire

// File: rtl/comparatore_window_stream.sv
// ============================================================================
//  Module      : comparatore_window_stream
//  Description : Registered window comparator (a <= b <= c) on a valid/ready
//                stream with a saturating in-window run counter and a
//                persistence flag. Define COMP_SIGNED_EN for signed compares.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module comparatore_window_stream #(
    parameter int WIDTH   = 3,
    parameter int PERSIST = 3,
    parameter int CNT_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    comparatore_window_stream_if.slave  strm
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_PERSIST = CNT_W'(PERSIST);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_c;
    logic             w_a_le_b;
    logic             w_b_le_c;
    logic             w_a_gt_c;
    logic             w_win;
    logic             w_in_ready;
    logic             w_accept;

    logic             out_valid_q, out_valid_d;
    logic             in_window_q, in_window_d;
    logic             inv_win_q,   inv_win_d;
    logic             stable_q,    stable_d;
    logic [CNT_W-1:0] run_cnt_q,   run_cnt_d;

    assign w_a = strm.a;
    assign w_b = strm.b;
    assign w_c = strm.c;

`ifdef COMP_SIGNED_EN
    assign w_a_le_b = $signed(w_a) <= $signed(w_b);
    assign w_b_le_c = $signed(w_b) <= $signed(w_c);
    assign w_a_gt_c = $signed(w_a) >  $signed(w_c);
`else
    assign w_a_le_b = w_a <= w_b;
    assign w_b_le_c = w_b <= w_c;
    assign w_a_gt_c = w_a >  w_c;
`endif

    // An empty window can never report membership
    assign w_win      = w_a_le_b && w_b_le_c && !w_a_gt_c;

    assign w_in_ready = !out_valid_q || strm.out_ready;
    assign w_accept   = strm.in_valid && w_in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        in_window_d = in_window_q;
        inv_win_d   = inv_win_q;
        stable_d    = stable_q;
        run_cnt_d   = run_cnt_q;

        if (w_accept) begin
            out_valid_d = 1'b1;
            in_window_d = w_win;
            inv_win_d   = w_a_gt_c;
            if (w_win) begin
                run_cnt_d = (run_cnt_q == c_CNT_MAX) ? c_CNT_MAX : run_cnt_q + 1'b1;
            end else begin
                run_cnt_d = '0;
            end
            // Flag follows the updated count so it lands with the completing result
            stable_d = (run_cnt_d >= c_PERSIST);
        end else if (strm.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            in_window_q <= 1'b0;
            inv_win_q   <= 1'b0;
            stable_q    <= 1'b0;
            run_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            in_window_q <= in_window_d;
            inv_win_q   <= inv_win_d;
            stable_q    <= stable_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    assign strm.in_ready  = w_in_ready;
    assign strm.out_valid = out_valid_q;
    assign strm.in_window = in_window_q;
    assign strm.inv_win   = inv_win_q;
    assign strm.stable    = stable_q;
    assign strm.run_cnt   = run_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_comparatore_window_stream.sv
// ============================================================================
//  Module      : tb_comparatore_window_stream
//  Description : Table-driven and scoreboard bench for the window comparator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_comparatore_window_stream;

    localparam int c_NVEC = 10;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
        logic       win;
        logic       inv;
    } vec_t;

    typedef struct packed {
        logic       win;
        logic       inv;
        logic       stable;
        logic [3:0] run;
    } exp_t;

    logic clk;
    logic rst;

    comparatore_window_stream_if #(.WIDTH(3), .CNT_W(4)) bus ();

    comparatore_window_stream #(
        .WIDTH   (3),
        .PERSIST (3),
        .CNT_W   (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .strm (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_run = 0;
    logic drv_win;
    logic drv_inv;
    exp_t sbq[$];
    vec_t vecs[c_NVEC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        logic inv;
        logic win;
`ifdef COMP_SIGNED_EN
        inv = $signed(a) > $signed(c);
        win = ($signed(a) <= $signed(b)) && ($signed(b) <= $signed(c));
`else
        inv = a > c;
        win = (a <= b) && (b <= c);
`endif
        return {win, inv};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input logic win, input logic inv);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        drv_win      = win;
        drv_inv      = inv;
    endtask

    // Scoreboard: retire the held result first, then record any new accept
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_in_window", int'(bus.in_window), int'(e.win));
                    chk("sb_inv_win",   int'(bus.inv_win),   int'(e.inv));
                    chk("sb_stable",    int'(bus.stable),    int'(e.stable));
                    chk("sb_run_cnt",   int'(bus.run_cnt),   int'(e.run));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t n;
                m_run    = drv_win ? ((m_run == 15) ? 15 : m_run + 1) : 0;
                n.win    = drv_win;
                n.inv    = drv_inv;
                n.stable = (m_run >= 3);
                n.run    = 4'(m_run);
                sbq.push_back(n);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_in_window"}, int'(bus.in_window), 0);
        chk({tag, "_inv_win"},   int'(bus.inv_win),   0);
        chk({tag, "_stable"},    int'(bus.stable),    0);
        chk({tag, "_run_cnt"},   int'(bus.run_cnt),   0);
        chk({tag, "_in_ready"},  int'(bus.in_ready),  1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd0, 3'd3, 3'd5, 1'b1, 1'b0};
        vecs[1] = '{3'd2, 3'd1, 3'd5, 1'b0, 1'b0};
        vecs[2] = '{3'd3, 3'd4, 3'd4, 1'b1, 1'b0};
        vecs[3] = '{3'd3, 3'd4, 3'd1, 1'b0, 1'b1};
        vecs[4] = '{3'd1, 3'd5, 3'd5, 1'b1, 1'b0};
        vecs[5] = '{3'd2, 3'd2, 3'd2, 1'b1, 1'b0};
        vecs[8] = '{3'd5, 3'd7, 3'd6, 1'b0, 1'b0};
`ifdef COMP_SIGNED_EN
        vecs[6] = '{3'd7, 3'd0, 3'd1, 1'b1, 1'b0};
        vecs[7] = '{3'd0, 3'd0, 3'd7, 1'b0, 1'b1};
        vecs[9] = '{3'd4, 3'd4, 3'd3, 1'b1, 1'b0};
`else
        vecs[6] = '{3'd7, 3'd0, 3'd1, 1'b0, 1'b1};
        vecs[7] = '{3'd0, 3'd0, 3'd7, 1'b1, 1'b0};
        vecs[9] = '{3'd4, 3'd4, 3'd3, 1'b0, 1'b1};
`endif

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.c = '0;
        drv_win = 1'b0; drv_inv = 1'b0;
        repeat (3) cyc();
        chk_all_zero("reset");
        rst = 1'b0;
        cyc();

        // Latency: result appears exactly one cycle after the accepting edge
        drive(3'd0, 3'd3, 3'd5, 1'b1, 1'b0);
        chk("lat_before_valid", int'(bus.out_valid), 0);
        cyc();
        bus.in_valid = 1'b0;
        chk("lat_after_valid",  int'(bus.out_valid), 1);
        chk("lat_in_window",    int'(bus.in_window), 1);
        cyc();
        cyc();

        // Table, back-to-back at full throughput
        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].win, vecs[i].inv);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(3'd1, 3'd5, 3'd5, 1'b1, 1'b0);
            cyc();
        end
        chk("run3_stable", int'(bus.stable), 1);
        bus.in_valid = 1'b0;
        repeat (2) cyc();

        // Saturation then a single miss
        for (int i = 0; i < 18; i++) begin
            drive(3'd1, 3'd5, 3'd5, 1'b1, 1'b0);
            cyc();
        end
        chk("sat_run_cnt", int'(bus.run_cnt), 15);
        chk("sat_stable",  int'(bus.stable),  1);
        drive(3'd2, 3'd1, 3'd5, 1'b0, 1'b0);
        cyc();
        chk("miss_run_cnt", int'(bus.run_cnt), 0);
        chk("miss_stable",  int'(bus.stable),  0);

        // Idle cycles between accepts must not disturb the run
        drive(3'd1, 3'd5, 3'd5, 1'b1, 1'b0);
        cyc();
        cyc();
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        drive(3'd1, 3'd5, 3'd5, 1'b1, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        chk("idle_run_cnt", int'(bus.run_cnt), 3);
        chk("idle_stable",  int'(bus.stable),  1);
        cyc();
        cyc();

        // Back-pressure hold, then reset in the middle of it
        bus.out_ready = 1'b0;
        drive(3'd1, 3'd5, 3'd5, 1'b1, 1'b0);
        cyc();
        drive(3'd2, 3'd1, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_in_ready",  int'(bus.in_ready),  0);
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_in_window", int'(bus.in_window), 1);
            chk("hold_inv_win",   int'(bus.inv_win),   0);
            chk("hold_run_cnt",   int'(bus.run_cnt),   4);
            chk("hold_stable",    int'(bus.stable),    1);
            cyc();
        end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk_all_zero("midrst");
        sbq.delete();
        m_run = 0;
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cyc();

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  ra, rb, rc;
            logic [1:0]  m;
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            rc = 3'($urandom_range(0, 7));
            if (i % 3 == 0) begin
                rb = 3'd4; ra = 3'd2; rc = 3'd6;
            end
            m = model(ra, rb, rc);
            drive(ra, rb, rc, m[1], m[0]);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) cyc();
        cyc();
        chk("drain_queue", sbq.size(), 0);
        chk("drain_out_valid", int'(bus.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
